// File: rtl/d_redirect_ctrl_if.sv
// Decode-stage control-flow bundle: jump/branch decode and hazard sources in,
// fetch/decode stall, flush and PC-select out.
interface d_redirect_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             i_d_valid;
  logic [1:0]       i_jump;
  logic [2:0]       i_bop;
  logic             i_rs_eq_rt;
  logic [4:0]       i_d_rs;
  logic [4:0]       i_d_rt;
  logic             i_ex_regwrite;
  logic             i_ex_memread;
  logic [4:0]       i_ex_rd;
  logic             i_mem_memread;
  logic [4:0]       i_mem_rd;
  logic             i_ext_stall;
  logic             o_stall_f;
  logic             o_stall_d;
  logic             o_flush_e;
  logic             o_flush_d;
  logic [1:0]       o_pc_sel;
  logic [CNT_W-1:0] o_redirect_cnt;

  // Pipeline side: drives decode/hazard info, consumes redirect controls.
  modport master (
    output i_d_valid, i_jump, i_bop, i_rs_eq_rt, i_d_rs, i_d_rt,
           i_ex_regwrite, i_ex_memread, i_ex_rd, i_mem_memread, i_mem_rd,
           i_ext_stall,
    input  o_stall_f, o_stall_d, o_flush_e, o_flush_d, o_pc_sel,
           o_redirect_cnt
  );

  modport slave (
    input  i_d_valid, i_jump, i_bop, i_rs_eq_rt, i_d_rs, i_d_rt,
           i_ex_regwrite, i_ex_memread, i_ex_rd, i_mem_memread, i_mem_rd,
           i_ext_stall,
    output o_stall_f, o_stall_d, o_flush_e, o_flush_d, o_pc_sel,
           o_redirect_cnt
  );
endinterface

// File: rtl/d_redirect_ctrl.sv
// Decode-stage branch/jump sequencer: waits out operand hazards on branch/jr
// sources, then resolves and redirects fetch, counting taken redirects.
module d_redirect_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  d_redirect_ctrl_if.slave  bus
);

  localparam logic [1:0] JMP_J   = 2'b01;
  localparam logic [1:0] JMP_JR  = 2'b10;
  localparam logic [2:0] BOP_BEQ = 3'b001;
  localparam logic [2:0] BOP_BNE = 3'b010;
  localparam logic [1:0] PC_SEQ  = 2'b00;
  localparam logic [1:0] PC_BR   = 2'b01;
  localparam logic [1:0] PC_JMP  = 2'b10;
  localparam logic [1:0] PC_REG  = 2'b11;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t           state;
  logic [1:0]       cnt;
  logic [CNT_W-1:0] redirect_cnt;

  logic       is_j, is_jr, jump_act, is_beq, is_bne, cfi;
  logic       use_rs, use_rt;
  logic       ex_hit, mem_hit;
  logic [1:0] need;
  logic       taken;
  logic [1:0] taken_sel;
  logic       stall_c, flush_e_c, resolve_c, redirect_c;

  // Instruction class; an active jump field overrides the branch op.
  assign is_j     = (bus.i_jump == JMP_J);
  assign is_jr    = (bus.i_jump == JMP_JR);
  assign jump_act = is_j | is_jr;
  assign is_beq   = ~jump_act & (bus.i_bop == BOP_BEQ);
  assign is_bne   = ~jump_act & (bus.i_bop == BOP_BNE);
  assign cfi      = bus.i_d_valid & (jump_act | is_beq | is_bne);

  assign use_rs = is_jr | is_beq | is_bne;
  assign use_rt = is_beq | is_bne;

  // Register 0 is hardwired, so a write to it is never a real dependency.
  assign ex_hit  = (bus.i_ex_rd != 5'd0) &&
                   ((use_rs && (bus.i_ex_rd == bus.i_d_rs)) ||
                    (use_rt && (bus.i_ex_rd == bus.i_d_rt)));
  assign mem_hit = (bus.i_mem_rd != 5'd0) &&
                   ((use_rs && (bus.i_mem_rd == bus.i_d_rs)) ||
                    (use_rt && (bus.i_mem_rd == bus.i_d_rt)));

  always_comb begin
    need = 2'd0;
    if (bus.i_ex_memread && ex_hit) begin
      need = 2'd2;
    end else if ((bus.i_ex_regwrite && ex_hit) ||
                 (bus.i_mem_memread && mem_hit)) begin
      need = 2'd1;
    end
  end

  // Branch outcome and redirect source for the instruction sitting in decode.
  always_comb begin
    taken     = 1'b0;
    taken_sel = PC_SEQ;
    if (cfi) begin
      if (is_j) begin
        taken     = 1'b1;
        taken_sel = PC_JMP;
      end else if (is_jr) begin
        taken     = 1'b1;
        taken_sel = PC_REG;
      end else if ((is_beq && bus.i_rs_eq_rt) || (is_bne && !bus.i_rs_eq_rt)) begin
        taken     = 1'b1;
        taken_sel = PC_BR;
      end
    end
  end

  always_comb begin
    stall_c   = 1'b0;
    flush_e_c = 1'b0;
    resolve_c = 1'b0;
    case (state)
      S_IDLE: begin
        if (cfi) begin
          if (need != 2'd0) begin
            stall_c   = 1'b1;
            flush_e_c = 1'b1;
          end else begin
            resolve_c = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (cnt != 2'd0) begin
          stall_c   = 1'b1;
          flush_e_c = 1'b1;
        end else begin
          resolve_c = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // A freeze suppresses the resolve so it is retried once the pipe moves.
  assign redirect_c = resolve_c & taken & ~bus.i_ext_stall;

  always_comb begin
    bus.o_stall_f      = 1'b0;
    bus.o_stall_d      = 1'b0;
    bus.o_flush_e      = 1'b0;
    bus.o_flush_d      = 1'b0;
    bus.o_pc_sel       = PC_SEQ;
    bus.o_redirect_cnt = '0;
    if (!i_rst) begin
      bus.o_redirect_cnt = redirect_cnt;
      if (bus.i_ext_stall) begin
        bus.o_stall_f = 1'b1;
        bus.o_stall_d = 1'b1;
      end else begin
        bus.o_stall_f = stall_c;
        bus.o_stall_d = stall_c;
        bus.o_flush_e = flush_e_c;
        bus.o_flush_d = redirect_c;
        bus.o_pc_sel  = redirect_c ? taken_sel : PC_SEQ;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= S_IDLE;
      cnt          <= 2'd0;
      redirect_cnt <= '0;
    end else if (!bus.i_ext_stall) begin
      case (state)
        S_IDLE: begin
          if (cfi && (need != 2'd0)) begin
            state <= S_WAIT;
            cnt   <= need - 2'd1;
          end
        end
        S_WAIT: begin
          if (cnt != 2'd0) begin
            cnt <= cnt - 2'd1;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
      if (redirect_c && (redirect_cnt != '1)) begin
        redirect_cnt <= redirect_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_d_redirect_ctrl.sv
// Bench for d_redirect_ctrl: directed scenarios plus random decode/hazard
// traffic, compared each cycle against a cycle-level behavioural model.
module tb_d_redirect_ctrl;

  localparam int unsigned CW_A = 16;
  localparam int unsigned CW_B = 2;
  localparam int unsigned MAX_A = 65535;
  localparam int unsigned MAX_B = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  d_redirect_ctrl_if #(.CNT_W(CW_A)) bus_a ();
  d_redirect_ctrl_if #(.CNT_W(CW_B)) bus_b ();

  d_redirect_ctrl #(.CNT_W(CW_A)) dut_a (.i_clk(clk), .i_rst(rst), .bus(bus_a.slave));
  d_redirect_ctrl #(.CNT_W(CW_B)) dut_b (.i_clk(clk), .i_rst(rst), .bus(bus_b.slave));

  typedef struct {
    bit       valid;
    bit [1:0] jump;
    bit [2:0] bop;
    bit       eq;
    bit [4:0] rs, rt;
    bit       exw, exl;
    bit [4:0] exrd;
    bit       meml;
    bit [4:0] memrd;
    bit       ext;
    bit       rst;
  } stim_t;

  stim_t s;

  // Model state: pending CFI and remaining stall cycles before its resolve.
  bit m_busy = 1'b0, n_busy;
  int m_left = 0, n_left;
  int unsigned m_cnt_a = 0, m_cnt_b = 0, n_cnt_a, n_cnt_b;

  bit e_sf, e_sd, e_fe, e_fd;
  int unsigned e_sel, e_cnt_a, e_cnt_b;
  logic [31:0] c_sf, c_fe, c_fd, c_sel, c_cnt_a, c_cnt_b;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive();
    rst = s.rst;
    bus_a.i_d_valid = s.valid;  bus_b.i_d_valid = s.valid;
    bus_a.i_jump = s.jump;      bus_b.i_jump = s.jump;
    bus_a.i_bop = s.bop;        bus_b.i_bop = s.bop;
    bus_a.i_rs_eq_rt = s.eq;    bus_b.i_rs_eq_rt = s.eq;
    bus_a.i_d_rs = s.rs;        bus_b.i_d_rs = s.rs;
    bus_a.i_d_rt = s.rt;        bus_b.i_d_rt = s.rt;
    bus_a.i_ex_regwrite = s.exw; bus_b.i_ex_regwrite = s.exw;
    bus_a.i_ex_memread = s.exl;  bus_b.i_ex_memread = s.exl;
    bus_a.i_ex_rd = s.exrd;      bus_b.i_ex_rd = s.exrd;
    bus_a.i_mem_memread = s.meml; bus_b.i_mem_memread = s.meml;
    bus_a.i_mem_rd = s.memrd;    bus_b.i_mem_rd = s.memrd;
    bus_a.i_ext_stall = s.ext;   bus_b.i_ext_stall = s.ext;
  endtask

  // Behavioural reference: classify, count hazard depth from a source list,
  // and track how many stall cycles remain before the resolve.
  task automatic model_eval();
    int kind;  // 0 none, 1 j/jal, 2 jr, 3 beq, 4 bne
    int srcs[$];
    int need;
    bit resolve, tkn;
    kind = 0;
    if (s.valid) begin
      if (s.jump == 2'b01) kind = 1;
      else if (s.jump == 2'b10) kind = 2;
      else if (s.bop == 3'b001) kind = 3;
      else if (s.bop == 3'b010) kind = 4;
    end
    if (kind == 2) srcs.push_back(int'(s.rs));
    if (kind >= 3) begin
      srcs.push_back(int'(s.rs));
      srcs.push_back(int'(s.rt));
    end
    need = 0;
    foreach (srcs[i]) begin
      if (srcs[i] != 0) begin
        if (s.exl && int'(s.exrd) == srcs[i]) need = 2;
        else if (((s.exw && int'(s.exrd) == srcs[i]) ||
                  (s.meml && int'(s.memrd) == srcs[i])) && need < 1) need = 1;
      end
    end
    n_busy = m_busy; n_left = m_left; n_cnt_a = m_cnt_a; n_cnt_b = m_cnt_b;
    e_sf = 0; e_sd = 0; e_fe = 0; e_fd = 0; e_sel = 0;
    e_cnt_a = s.rst ? 0 : m_cnt_a;
    e_cnt_b = s.rst ? 0 : m_cnt_b;
    if (s.rst) begin
      n_busy = 0; n_left = 0; n_cnt_a = 0; n_cnt_b = 0;
    end else if (s.ext) begin
      e_sf = 1; e_sd = 1;
    end else begin
      resolve = 0;
      if (m_busy) begin
        if (m_left > 0) begin
          e_sf = 1; e_sd = 1; e_fe = 1; n_left = m_left - 1;
        end else begin
          resolve = 1; n_busy = 0;
        end
      end else if (kind != 0) begin
        if (need > 0) begin
          e_sf = 1; e_sd = 1; e_fe = 1; n_busy = 1; n_left = need - 1;
        end else begin
          resolve = 1;
        end
      end
      tkn = (kind == 1) || (kind == 2) || (kind == 3 && s.eq) || (kind == 4 && !s.eq);
      if (resolve && tkn) begin
        e_fd = 1;
        e_sel = (kind == 1) ? 2 : (kind == 2) ? 3 : 1;
        n_cnt_a = (m_cnt_a < MAX_A) ? m_cnt_a + 1 : MAX_A;
        n_cnt_b = (m_cnt_b < MAX_B) ? m_cnt_b + 1 : MAX_B;
      end
    end
  endtask

  // One clock: drive, compare mid-cycle, then advance the model at the edge.
  task automatic apply();
    drive();
    #4;
    model_eval();
    c_sf = 32'(bus_a.o_stall_f);  c_fe = 32'(bus_a.o_flush_e);
    c_fd = 32'(bus_a.o_flush_d);  c_sel = 32'(bus_a.o_pc_sel);
    c_cnt_a = 32'(bus_a.o_redirect_cnt); c_cnt_b = 32'(bus_b.o_redirect_cnt);
    check("stall_f", 32'(bus_a.o_stall_f), 32'(e_sf));
    check("stall_d", 32'(bus_a.o_stall_d), 32'(e_sd));
    check("flush_e", 32'(bus_a.o_flush_e), 32'(e_fe));
    check("flush_d", 32'(bus_a.o_flush_d), 32'(e_fd));
    check("pc_sel", 32'(bus_a.o_pc_sel), e_sel);
    check("cnt16", 32'(bus_a.o_redirect_cnt), e_cnt_a);
    check("cnt2", 32'(bus_b.o_redirect_cnt), e_cnt_b);
    check("pc_sel_b", 32'(bus_b.o_pc_sel), e_sel);
    @(posedge clk);
    m_busy = n_busy; m_left = n_left; m_cnt_a = n_cnt_a; m_cnt_b = n_cnt_b;
    #1;
  endtask

  task automatic idle();
    s = '{default: 0};
  endtask

  task automatic do_reset();
    idle(); s.rst = 1; apply(); apply(); s.rst = 0;
  endtask

  function automatic bit [4:0] pick();
    int r = $urandom_range(0, 4);
    return (r == 4) ? 5'd31 : 5'(r);
  endfunction

  int unsigned exp_sat[5] = '{1, 2, 3, 3, 3};
  bit hold;

  initial begin
    idle(); s.rst = 1;
    drive();
    #4;
    check("reset_stall", 32'(bus_a.o_stall_f), 32'd0);
    check("reset_cnt", 32'(bus_a.o_redirect_cnt), 32'd0);
    @(posedge clk); #1;
    do_reset();

    // beq taken, no hazard: same-cycle redirect
    idle(); s.valid = 1; s.bop = 3'b001; s.rs = 3; s.rt = 4; s.eq = 1; apply();
    check("t1_sel", c_sel, 32'd1); check("t1_fd", c_fd, 32'd1); check("t1_sf", c_sf, 32'd0);
    idle(); apply();
    check("t1_cnt", c_cnt_a, 32'd1);

    // bne behind EX load: two stall cycles then redirect
    idle(); s.valid = 1; s.bop = 3'b010; s.rs = 1; s.rt = 5; s.exl = 1; s.exrd = 5; apply();
    check("t2_s0", c_sf, 32'd1); check("t2_fe0", c_fe, 32'd1);
    s.exl = 0; s.exrd = 0; apply();
    check("t2_s1", c_sf, 32'd1);
    apply();
    check("t2_sel", c_sel, 32'd1); check("t2_fd", c_fd, 32'd1); check("t2_s2", c_sf, 32'd0);

    // jr behind EX ALU write: one stall; jal ignores the same hazard
    idle(); s.valid = 1; s.jump = 2'b10; s.rs = 31; s.exw = 1; s.exrd = 31; apply();
    check("t3_s0", c_sf, 32'd1);
    s.exw = 0; apply();
    check("t3_sel", c_sel, 32'd3); check("t3_fd", c_fd, 32'd1);
    idle(); s.valid = 1; s.jump = 2'b01; s.rs = 31; s.exw = 1; s.exrd = 31; apply();
    check("t3_jal_sf", c_sf, 32'd0); check("t3_jal_sel", c_sel, 32'd2);

    // r0 never hazards; not-taken beq leaves counter alone
    idle(); s.valid = 1; s.bop = 3'b001; s.exl = 1; apply();
    check("t4_sf", c_sf, 32'd0); check("t4_sel", c_sel, 32'd0); check("t4_fd", c_fd, 32'd0);
    idle(); apply();
    check("t4_cnt", c_cnt_a, 32'd4);

    // freeze during an N=2 wait
    do_reset();
    idle(); s.valid = 1; s.bop = 3'b001; s.rs = 2; s.eq = 1; s.exl = 1; s.exrd = 2; apply();
    check("t5_s0", c_sf, 32'd1);
    s.exl = 0; s.ext = 1;
    for (int i = 0; i < 3; i++) begin
      apply();
      check("t5_frz_sf", c_sf, 32'd1); check("t5_frz_fe", c_fe, 32'd0); check("t5_frz_sel", c_sel, 32'd0);
    end
    s.ext = 0; apply();
    check("t5_s4", c_sf, 32'd1); check("t5_fe4", c_fe, 32'd1);
    apply();
    check("t5_sel", c_sel, 32'd1); check("t5_fd", c_fd, 32'd1);

    // reset mid-wait abandons the branch
    do_reset();
    idle(); s.valid = 1; s.bop = 3'b001; s.rs = 2; s.eq = 1; s.exl = 1; s.exrd = 2; apply();
    s.rst = 1; apply();
    check("t6_rst_sf", c_sf, 32'd0);
    idle(); apply();
    check("t6_sel", c_sel, 32'd0); check("t6_fd", c_fd, 32'd0);
    apply();
    check("t6_cnt", c_cnt_a, 32'd0);

    // 2-bit counter saturation with back-to-back jumps
    for (int i = 0; i < 6; i++) begin
      idle();
      if (i < 5) begin s.valid = 1; s.jump = 2'b01; end
      apply();
      if (i > 0) check("cnt2_sat", c_cnt_b, 32'(exp_sat[i-1]));
    end

    // random traffic; decode inputs held while decode is stalled
    do_reset();
    hold = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!hold) begin
        s.valid = ($urandom_range(0, 7) != 0);
        s.jump  = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(0, 3));
        s.bop   = 3'($urandom_range(0, 7));
        s.rs    = pick();
        s.rt    = pick();
      end
      s.eq    = 1'($urandom_range(0, 1));
      s.exw   = 1'($urandom_range(0, 1));
      s.exl   = ($urandom_range(0, 3) == 0);
      s.exrd  = pick();
      s.meml  = ($urandom_range(0, 3) == 0);
      s.memrd = pick();
      s.ext   = ($urandom_range(0, 5) == 0);
      s.rst   = ($urandom_range(0, 49) == 0);
      apply();
      hold = e_sd;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/d_redirect_ctrl.md
Name: d_redirect_ctrl

Overview:
Decode-stage control-flow sequencer for the 5-stage MIPS pipeline. It consumes the jump/branch decode (jump class, branch op) and the decode-stage register-compare result. It detects operand hazards on branch/jr sources, stalls fetch/decode for the required cycles while injecting bubbles into EX, then resolves the branch and drives PC-select and the decode flush. It also keeps a saturating count of taken redirects.

Parameters:
CNT_W, 16, width of the taken-redirect counter o_redirect_cnt

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_d_valid  in  1  decode stage holds a valid instruction
i_jump  in  2  00 none, 01 j/jal, 10 jr, 11 reserved (treated as none)
i_bop  in  3  001 beq, 010 bne, others none
i_rs_eq_rt  in  1  decode-stage compare (rs==rt), valid once hazards clear
i_d_rs  in  5  decode rs index
i_d_rt  in  5  decode rt index
i_ex_regwrite  in  1  EX instruction writes a register
i_ex_memread  in  1  EX instruction is a load
i_ex_rd  in  5  EX destination index
i_mem_memread  in  1  MEM instruction is a load
i_mem_rd  in  5  MEM destination index
i_ext_stall  in  1  global pipeline freeze (memory wait)
o_stall_f  out  1  hold PC
o_stall_d  out  1  hold IF/ID register
o_flush_e  out  1  insert bubble into ID/EX
o_flush_d  out  1  squash IF/ID on next edge (wrong-path fetch)
o_pc_sel  out  2  00 PC+4, 01 branch target, 10 jump target, 11 register (jr)
o_redirect_cnt  out  CNT_W  saturating count of taken redirects

Behaviour:
- Control-flow instruction (CFI): i_d_valid & (i_bop in {001,010} or i_jump in {01,10}). If both fields are active, i_jump has priority.
- Sources: beq/bne use rs and rt; jr uses rs only; j/jal use none. Index 0 never causes a hazard.
- Required stall N, evaluated in S_IDLE:
  - N=2 if an EX load targets a source.
  - Otherwise N=1 if an EX regwrite (non-load) targets a source, or a MEM load targets a source.
  - Otherwise N=0.
- State: S_IDLE, S_WAIT; 2-bit wait counter cnt.
- S_IDLE with CFI and N=0: resolve in this cycle; stay in S_IDLE.
- S_IDLE with CFI and N>0: assert o_stall_f, o_stall_d and o_flush_e; cnt<=N-1; go to S_WAIT.
- S_WAIT with cnt!=0: stall and flush_e as above; cnt<=cnt-1.
- S_WAIT with cnt==0: resolve; go to S_IDLE. Hazards are not re-evaluated in S_WAIT.
- Resolve cycle: taken = j/jal | jr | (beq & i_rs_eq_rt) | (bne & ~i_rs_eq_rt).
  - If taken: o_pc_sel = 01 (branch), 10 (j/jal) or 11 (jr); o_flush_d=1; o_redirect_cnt increments, holding at 2^CNT_W-1.
  - Not taken: o_pc_sel=00, no flush.
- Latency: a branch in D at cycle t resolves at t, t+1 or t+2 for N=0/1/2. The target is fetched at the following edge.
- i_ext_stall=1: o_stall_f=o_stall_d=1; o_flush_e=o_flush_d=0; o_pc_sel=00. State, cnt and counter hold; no resolve occurs. Resolve is retried on the first cycle with i_ext_stall=0.
- Outputs are combinational from state, cnt and inputs. State, cnt and o_redirect_cnt are registered.
- Defaults: all 1-bit outputs 0, o_pc_sel=00 when no CFI is being processed.
- Reset: i_rst=1 on an edge sets S_IDLE, cnt=0, o_redirect_cnt=0. While i_rst=1, all outputs are forced to 0. Reset mid-S_WAIT abandons the pending CFI, with no redirect.
- Non-CFI or i_d_valid=0 in S_IDLE: all outputs default; no stall, even if hazards exist (load-use for ALU ops is handled elsewhere).

Test Plan:
- beq rs=3, rt=4, no EX/MEM writes, i_rs_eq_rt=1 -> same cycle o_pc_sel=01, o_flush_d=1, no stall; o_redirect_cnt 0->1.
- bne rt=5 with EX load rd=5, i_rs_eq_rt=0 -> stall/flush_e for cycles t, t+1; t+2 o_pc_sel=01, o_flush_d=1.
- jr rs=31 with EX ALU write rd=31 -> one stall cycle, then o_pc_sel=11, o_flush_d=1; jal with same hazard -> no stall, o_pc_sel=10.
- beq rs=0 with EX load rd=0, i_rs_eq_rt=0 -> no stall, o_pc_sel=00, no flush, counter unchanged.
- EX-load hazard (N=2), i_ext_stall=1 for 3 cycles starting at t+1 -> stalls continue with o_flush_e=0 during the freeze; resolve exactly one non-frozen cycle after; i_rst asserted at t+1 instead -> no redirect, counter 0.
- CNT_W=2, five taken j instructions -> o_redirect_cnt = 1, 2, 3, 3, 3.
